// File: rtl/cdr_pkg.sv
// Shared types, widths and helpers for the CDR phase detector slice.
package cdr_pkg;

    localparam int NB_P_W = 6;
    localparam int ACC_W  = 4;
    localparam int RUN_W  = 4;

    typedef enum logic {ACQ, TRACK} cdr_state_t;
    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic [RUN_W-1:0]        run_t;

    localparam acc_t ACC_ZERO = 4'sd0;
    localparam acc_t ACC_ONE  = 4'sd1;
    localparam acc_t ACC_MAX  = 4'sd7;
    localparam acc_t ACC_MIN  = -4'sd7;
    localparam run_t RUN_MAX  = 4'd15;

    // One vote step with symmetric saturation; a simultaneous up/down is ignored.
    function automatic acc_t acc_sat_add(input acc_t a, input logic up, input logic dn);
        acc_t r;
        if (up && !dn && (a != ACC_MAX)) begin
            r = a + ACC_ONE;
        end else if (dn && !up && (a != ACC_MIN)) begin
            r = a - ACC_ONE;
        end else begin
            r = a;
        end
        return r;
    endfunction

    function automatic run_t run_inc(input run_t c);
        run_t r;
        if (c != RUN_MAX) begin
            r = c + 4'd1;
        end else begin
            r = c;
        end
        return r;
    endfunction

endpackage

// File: rtl/cdr_phase_detector_if.sv
// Strobe/data bundle between the CDR period counter, this detector and the despreader.
interface cdr_phase_detector_if;
    import cdr_pkg::*;

    logic              i_data;
    logic              i_en_d;
    logic              i_en_m;
    logic              i_en_f;
    logic              i_en;
    logic              i_en_freq_synch;
    logic [NB_P_W-1:0] o_nb_P;
    logic              o_data;
    logic              o_data_valid;
    logic              o_early;
    logic              o_late;
    logic              o_locked;

    modport master (
        output i_data, i_en_d, i_en_m, i_en_f, i_en, i_en_freq_synch,
        input  o_nb_P, o_data, o_data_valid, o_early, o_late, o_locked
    );

    modport slave (
        input  i_data, i_en_d, i_en_m, i_en_f, i_en, i_en_freq_synch,
        output o_nb_P, o_data, o_data_valid, o_early, o_late, o_locked
    );

endinterface

// File: rtl/cdr_vote_acc.sv
// Saturating signed early/late vote accumulator with threshold decision.
// The decision sees the accumulator after the current cycle's vote.
module cdr_vote_acc
    import cdr_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_vote_up,
    input  logic i_vote_dn,
    input  logic i_upd,
    input  acc_t i_th,
    output logic o_corr_up,
    output logic o_corr_dn
);

    acc_t acc_r;
    acc_t acc_next_s;
    acc_t neg_th_s;

    assign acc_next_s = acc_sat_add(acc_r, i_vote_up, i_vote_dn);
    assign neg_th_s   = -i_th;

    // Threshold compare, only meaningful on a period update.
    always_comb begin
        o_corr_up = 1'b0;
        o_corr_dn = 1'b0;
        if (i_upd) begin
            if (acc_next_s >= i_th) begin
                o_corr_up = 1'b1;
            end else if (acc_next_s <= neg_th_s) begin
                o_corr_dn = 1'b1;
            end else begin
                o_corr_up = 1'b0;
            end
        end else begin
            o_corr_dn = 1'b0;
        end
    end

    // Accumulator register; a correction consumes the accumulated votes.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            acc_r <= ACC_ZERO;
        end else if (o_corr_up || o_corr_dn) begin
            acc_r <= ACC_ZERO;
        end else begin
            acc_r <= acc_next_s;
        end
    end

endmodule

// File: rtl/cdr_phase_detector.sv
// Early/late phase detector and period-correction controller of the CDR loop.
// Samples the chip stream at d/m/f strobes, votes per symbol and steers o_nb_P.
module cdr_phase_detector
    import cdr_pkg::*;
#(
    parameter int NB_P_NOM = 24,
    parameter int TH_ACQ   = 2,
    parameter int TH_TRK   = 4,
    parameter int LOCK_CNT = 8,
    parameter int LOSS_CNT = 4
) (
    input logic                  i_clk,
    input logic                  i_rst,
    cdr_phase_detector_if.slave  bus
);

    localparam logic [NB_P_W-1:0] NB_P_NOM_C = NB_P_W'(NB_P_NOM);
    localparam run_t              LOCK_CNT_C = RUN_W'(LOCK_CNT);
    localparam run_t              LOSS_CNT_C = RUN_W'(LOSS_CNT);
    localparam run_t              RUN_ZERO   = 4'd0;

    logic s_d_r, s_m_r, s_f_r;
    logic seen_d_r, seen_m_r, seen_f_r;
    logic all_seen_s, late_raw_s, early_raw_s;
    logic vote_up_s, vote_dn_s;
    logic corr_up_s, corr_dn_s;

    logic data_r, data_valid_r, early_r, late_r, locked_r;

    cdr_state_t        state_r, state_n;
    run_t              ok_run_r, ok_run_n;
    run_t              corr_run_r, corr_run_n;
    logic [NB_P_W-1:0] nb_p_r, nb_p_n;
    logic [NB_P_W-1:0] step_s;
    acc_t              th_s;

    assign all_seen_s  = seen_d_r & seen_m_r & seen_f_r;
    assign late_raw_s  = s_d_r ^ s_m_r;
    assign early_raw_s = s_m_r ^ s_f_r;

    // Strobe capture; a strobe landing on i_en belongs to the next window.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            s_d_r    <= 1'b0;
            s_m_r    <= 1'b0;
            s_f_r    <= 1'b0;
            seen_d_r <= 1'b0;
            seen_m_r <= 1'b0;
            seen_f_r <= 1'b0;
        end else begin
            if (bus.i_en_d) begin
                s_d_r    <= bus.i_data;
                seen_d_r <= 1'b1;
            end else if (bus.i_en) begin
                seen_d_r <= 1'b0;
            end
            if (bus.i_en_m) begin
                s_m_r    <= bus.i_data;
                seen_m_r <= 1'b1;
            end else if (bus.i_en) begin
                seen_m_r <= 1'b0;
            end
            if (bus.i_en_f) begin
                s_f_r    <= bus.i_data;
                seen_f_r <= 1'b1;
            end else if (bus.i_en) begin
                seen_f_r <= 1'b0;
            end
        end
    end

    // Per-symbol vote, only from a complete window with exactly one transition.
    always_comb begin
        vote_up_s = 1'b0;
        vote_dn_s = 1'b0;
        if (bus.i_en && all_seen_s) begin
            vote_up_s = early_raw_s & ~late_raw_s;
            vote_dn_s = late_raw_s & ~early_raw_s;
        end else begin
            vote_up_s = 1'b0;
        end
    end

    // Loop gain and threshold follow the lock state.
    always_comb begin
        step_s = 6'd2;
        th_s   = acc_t'(TH_ACQ);
        if (state_r == TRACK) begin
            step_s = 6'd1;
            th_s   = acc_t'(TH_TRK);
        end else begin
            step_s = 6'd2;
        end
    end

    cdr_vote_acc u_vote_acc (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_vote_up (vote_up_s),
        .i_vote_dn (vote_dn_s),
        .i_upd     (bus.i_en_freq_synch),
        .i_th      (th_s),
        .o_corr_up (corr_up_s),
        .o_corr_dn (corr_dn_s)
    );

    // Period selection, run counting and lock state transitions on each update.
    always_comb begin
        state_n    = state_r;
        ok_run_n   = ok_run_r;
        corr_run_n = corr_run_r;
        nb_p_n     = nb_p_r;
        if (bus.i_en_freq_synch) begin
            if (corr_up_s) begin
                nb_p_n = NB_P_NOM_C + step_s;
            end else if (corr_dn_s) begin
                nb_p_n = NB_P_NOM_C - step_s;
            end else begin
                nb_p_n = NB_P_NOM_C;
            end
            if (corr_up_s || corr_dn_s) begin
                corr_run_n = run_inc(corr_run_r);
                ok_run_n   = RUN_ZERO;
            end else begin
                ok_run_n   = run_inc(ok_run_r);
                corr_run_n = RUN_ZERO;
            end
            case (state_r)
                ACQ: begin
                    if (ok_run_n >= LOCK_CNT_C) begin
                        state_n    = TRACK;
                        ok_run_n   = RUN_ZERO;
                        corr_run_n = RUN_ZERO;
                    end else begin
                        state_n = ACQ;
                    end
                end
                TRACK: begin
                    if (corr_run_n >= LOSS_CNT_C) begin
                        state_n    = ACQ;
                        ok_run_n   = RUN_ZERO;
                        corr_run_n = RUN_ZERO;
                    end else begin
                        state_n = TRACK;
                    end
                end
                default: begin
                    state_n    = ACQ;
                    ok_run_n   = RUN_ZERO;
                    corr_run_n = RUN_ZERO;
                end
            endcase
        end else begin
            state_n = state_r;
        end
    end

    // State, period and lock registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_r    <= ACQ;
            ok_run_r   <= RUN_ZERO;
            corr_run_r <= RUN_ZERO;
            nb_p_r     <= NB_P_NOM_C;
            locked_r   <= 1'b0;
        end else begin
            state_r    <= state_n;
            ok_run_r   <= ok_run_n;
            corr_run_r <= corr_run_n;
            nb_p_r     <= nb_p_n;
            locked_r   <= (state_n == TRACK);
        end
    end

    // Evaluation outputs; bit and votes hold until the next evaluation.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            data_r       <= 1'b0;
            data_valid_r <= 1'b0;
            early_r      <= 1'b0;
            late_r       <= 1'b0;
        end else begin
            data_valid_r <= bus.i_en;
            if (bus.i_en) begin
                data_r  <= s_m_r;
                early_r <= vote_up_s;
                late_r  <= vote_dn_s;
            end
        end
    end

    assign bus.o_nb_P       = nb_p_r;
    assign bus.o_data       = data_r;
    assign bus.o_data_valid = data_valid_r;
    assign bus.o_early      = early_r;
    assign bus.o_late       = late_r;
    assign bus.o_locked     = locked_r;

endmodule
